// File: rtl/mem_sequencer.sv
// Multi-cycle fetch/decode/data/commit sequencer for a single shared memory port.
// A bus timeout parks the sequencer in HALT until reset.
module mem_sequencer #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_addr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  wr,
  output logic [31:0] instruction,
  output logic [31:0] d_rdata,
  output logic        commit,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_req,
  output logic        m_we,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        bus_err,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DATA,
    S_COMMIT,
    S_HALT
  } state_t;

  localparam logic [7:0] TO = TIMEOUT[7:0];

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [7:0]  cnt_inc;
  logic [1:0]  op_q;
  logic [31:0] instr_q;
  logic [31:0] rdata_q;
  logic [31:0] instret_q;
  logic        err_q;
  logic        busy;
  logic        timeout;
  logic        is_store;
  logic        is_load;

  assign cnt_inc  = wait_cnt + 8'd1;
  assign busy     = (state == S_FETCH) || (state == S_DATA);
  assign timeout  = busy && !m_ack && (TO != 8'd0) && (cnt_inc == TO);
  assign is_store = (op_q == 2'b10);
  assign is_load  = (op_q == 2'b01);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (m_ack)        state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_HALT;
      end
      S_DECODE: begin
        unique case (1'b1)
          (wr == 2'b01),
          (wr == 2'b10): state_nxt = S_DATA;
          default:       state_nxt = S_COMMIT;
        endcase
      end
      S_DATA: begin
        if (m_ack)        state_nxt = S_COMMIT;
        else if (timeout) state_nxt = S_HALT;
      end
      S_COMMIT: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= 8'd0;
      op_q      <= 2'b00;
      instr_q   <= NOP_INSTR;
      rdata_q   <= 32'd0;
      instret_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      // Zero outside an access, so every FETCH/DATA entry starts at 0
      if (busy && !m_ack) wait_cnt <= cnt_inc;
      else                wait_cnt <= 8'd0;
      if (state == S_DECODE) op_q <= wr;
      if (state == S_FETCH && m_ack) instr_q <= m_rdata;
      if (state == S_DATA && m_ack && is_load) rdata_q <= m_rdata;
      if (state == S_COMMIT) instret_q <= instret_q + 32'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  // Port controls come from state and the command latched in DECODE
  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = pc_addr;
    m_wdata = 32'd0;
    commit  = 1'b0;
    unique case (state)
      S_FETCH:  m_req = 1'b1;
      S_DATA: begin
        m_req   = 1'b1;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_we    = is_store;
      end
      S_COMMIT: commit = 1'b1;
      default: ;
    endcase
  end

  assign instruction = instr_q;
  assign d_rdata     = rdata_q;
  assign instret     = instret_q;
  assign bus_err     = err_q;

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum cycles M_REQ may wait for M_ACK (1..255); 0 disables timeout.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, instruction register value after reset.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 PC_ADDR  in  32  fetch address from core PC output (NEXT).
REQ-006 D_ADDR  in  32  data address from core ALU.
REQ-007 D_WDATA  in  32  store data from core.
REQ-008 WR  in  2  core memory command: 00 none, 01 load, 10 store, 11 treated as none.
REQ-009 INSTRUCTION  out  32  registered instruction word driven to core decoder.
REQ-010 D_RDATA  out  32  registered load data driven to core D_IN.
REQ-011 COMMIT  out  1  one-cycle pulse; core updates PC and register file only when high.
REQ-012 M_ADDR / M_WDATA  out  32 / 32  shared memory port address and write data.
REQ-013 M_REQ  out  1  memory request; M_WE  out  1  write enable, valid only with M_REQ.
REQ-014 M_RDATA  in  32  memory read data, valid with M_ACK; M_ACK  in  1  access complete.
REQ-015 BUS_ERR  out  1  sticky timeout flag; INSTRET  out  32  retired-instruction counter.

Function
REQ-016 States: IDLE, FETCH, DECODE, DATA, COMMIT, HALT; all outputs except INSTRUCTION/D_RDATA/INSTRET/BUS_ERR are decoded from state alone (Moore).
REQ-017 IDLE: M_REQ=0; unconditional transition to FETCH on next edge.
REQ-018 FETCH: M_REQ=1, M_WE=0, M_ADDR=PC_ADDR; on M_ACK=1, INSTRUCTION<=M_RDATA, go DECODE.
REQ-019 DECODE: M_REQ=0, single cycle; WR sampled at end: 01 or 10 -> DATA, 00 or 11 -> COMMIT.
REQ-020 DATA: M_REQ=1, M_ADDR=D_ADDR, M_WDATA=D_WDATA, M_WE=1 iff WR=10; on M_ACK: if load, D_RDATA<=M_RDATA; go COMMIT.
REQ-021 Store SHALL NOT modify D_RDATA.
REQ-022 COMMIT: COMMIT=1, M_REQ=0, INSTRET<=INSTRET+1 (mod 2^32, wraps to 0); go FETCH.
REQ-023 Outside FETCH/DATA, M_ADDR SHALL equal PC_ADDR, M_WDATA=0, M_WE=0.
REQ-024 Handshake: while M_REQ=1, M_ADDR/M_WE/M_WDATA SHALL be stable until the edge sampling M_ACK=1; M_ACK while M_REQ=0 SHALL be ignored.
REQ-025 Latency with M_ACK in first request cycle: non-memory instruction 3 cycles FETCH->COMMIT; load/store 4 cycles; each wait cycle adds one.
REQ-026 Wait counter (8-bit) clears on entry to FETCH/DATA, increments each cycle in FETCH/DATA without M_ACK.
REQ-027 If TIMEOUT!=0 and counter reaches TIMEOUT without M_ACK, go HALT and set BUS_ERR=1 on that edge.
REQ-028 M_ACK on the same cycle the counter reaches TIMEOUT SHALL win: access completes normally, no error.
REQ-029 HALT: M_REQ=0, COMMIT=0, no further state change; exit only via reset; BUS_ERR held 1.
REQ-030 INSTRET increments only in COMMIT; never in HALT.

Reset
REQ-031 RST=0 asynchronously forces state IDLE, M_REQ=0, M_WE=0, COMMIT=0, INSTRUCTION=NOP_INSTR, D_RDATA=0, INSTRET=0, BUS_ERR=0, wait counter=0.
REQ-032 Reset asserted mid-request SHALL drop M_REQ immediately; the abandoned access is not retried; after release sequence restarts IDLE->FETCH.

Verification
REQ-033 Reset release, PC_ADDR=0, M_ACK=1 immediately, M_RDATA=0x00500093, WR=00 -> M_REQ high cycle 1, INSTRUCTION=0x00500093 cycle 2, COMMIT pulse cycle 3, INSTRET=1.
REQ-034 Load: WR=01, D_ADDR=0x100, M_ACK after 2 wait cycles returning 0xDEADBEEF -> M_ADDR=0x100, M_WE=0 held 3 cycles, D_RDATA=0xDEADBEEF, COMMIT one cycle later.
REQ-035 Store: WR=10, D_ADDR=0x104, D_WDATA=0x12345678 -> M_WE=1, M_WDATA=0x12345678 during DATA only; D_RDATA unchanged.
REQ-036 Timeout: TIMEOUT=4, M_ACK held 0 in FETCH -> M_REQ drops after 4 cycles, BUS_ERR=1 sticky, no COMMIT, INSTRET unchanged until RST=0.
REQ-037 Boundary: M_ACK on 4th wait cycle with TIMEOUT=4 -> no error, normal COMMIT; INSTRET preloaded via 2^32-1 commits (or forced) wraps to 0.
REQ-038 RST=0 asserted during DATA wait -> M_REQ=0 same cycle, INSTRUCTION=0x00000013, restart from IDLE after release.
